// File: rtl/anabellek_hakem.sv
// Main-memory port arbiter between the fetch (getir) and data (bellek) cache controllers.
// Optional round-robin arbitration when HAKEM_DONUSUMLU_EN is defined; fixed bellek-over-getir priority otherwise.
module anabellek_hakem #(
   parameter int unsigned ADRES_BIT   = 32,
   parameter int unsigned OBEK_BIT    = 128,
   parameter int unsigned ZAMAN_ASIMI = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 getir_istek_i,
   input  logic [ADRES_BIT-1:0] getir_adres_i,
   output logic                 getir_musait_o,
   output logic                 getir_veri_hazir_o,
   output logic [OBEK_BIT-1:0]  getir_obek_o,
   input  logic                 bellek_istek_i,
   input  logic [ADRES_BIT-1:0] bellek_adres_i,
   input  logic                 bellek_yaz_i,
   input  logic [OBEK_BIT-1:0]  bellek_yaz_obek_i,
   output logic                 bellek_musait_o,
   output logic                 bellek_veri_hazir_o,
   output logic [OBEK_BIT-1:0]  bellek_obek_o,
   output logic                 anabellek_istek_o,
   output logic [ADRES_BIT-1:0] anabellek_adres_o,
   output logic                 anabellek_oku_o,
   output logic                 anabellek_yaz_o,
   output logic [OBEK_BIT-1:0]  anabellek_yaz_obek_o,
   input  logic                 anabellek_musait_i,
   input  logic                 anabellek_veri_hazir_i,
   input  logic [OBEK_BIT-1:0]  anabellek_obek_i,
   output logic                 zaman_asimi_o
);

   localparam int unsigned SAYAC_BIT = $clog2(ZAMAN_ASIMI);
   localparam logic [SAYAC_BIT-1:0] SON_SAYI = SAYAC_BIT'(ZAMAN_ASIMI - 1);
   localparam logic [OBEK_BIT-1:0] NOP_OBEK = {(OBEK_BIT / 32){32'h0000_0013}};
   localparam logic GETIR  = 1'b0;
   localparam logic BELLEK = 1'b1;

   typedef enum logic [1:0] {BOSTA, ISTEK, YANIT, BITTI} durum_t;

   durum_t                r_durum;
   logic                  r_sahip;
   logic [ADRES_BIT-1:0]  r_adres;
   logic                  r_yaz;
   logic [OBEK_BIT-1:0]   r_yobek;
   logic [SAYAC_BIT-1:0]  r_sayac;
   logic                  r_mem_istek;
   logic                  r_mem_oku;
   logic                  r_mem_yaz;
   logic                  r_musait;
   logic                  r_getir_hazir;
   logic                  r_bellek_hazir;
   logic [OBEK_BIT-1:0]   r_getir_obek;
   logic [OBEK_BIT-1:0]   r_bellek_obek;
   logic                  r_zaman;

   durum_t                w_durum_n;
   logic                  w_sahip_n;
   logic [ADRES_BIT-1:0]  w_adres_n;
   logic                  w_yaz_n;
   logic [OBEK_BIT-1:0]   w_yobek_n;
   logic [SAYAC_BIT-1:0]  w_sayac_n;
   logic [OBEK_BIT-1:0]   w_obek_n;
   logic                  w_zaman_n;
   logic                  w_secim;
   logic                  w_son;

   // Winner selection among current requesters (BELLEK = 1)
`ifdef HAKEM_DONUSUMLU_EN
   always_comb begin
      w_secim = bellek_istek_i;
      if (getir_istek_i && bellek_istek_i)
         w_secim = ~r_sahip;
   end
`else
   always_comb begin
      w_secim = bellek_istek_i;
   end
`endif

   assign w_son = (r_sayac == SON_SAYI);

   // Next-state, next transaction context and completion payload
   always_comb begin
      w_durum_n = r_durum;
      w_sahip_n = r_sahip;
      w_adres_n = r_adres;
      w_yaz_n   = r_yaz;
      w_yobek_n = r_yobek;
      w_sayac_n = r_sayac;
      w_obek_n  = '0;
      w_zaman_n = 1'b0;
      case (r_durum)
         BOSTA: begin
            if (getir_istek_i || bellek_istek_i) begin
               w_sahip_n = w_secim;
               w_adres_n = w_secim ? bellek_adres_i : getir_adres_i;
               w_yaz_n   = w_secim & bellek_yaz_i;
               w_yobek_n = w_secim ? bellek_yaz_obek_i : '0;
               w_sayac_n = '0;
               w_durum_n = ISTEK;
            end
         end
         ISTEK: begin
            w_sayac_n = r_sayac + SAYAC_BIT'(1);
            if (w_son) begin
               w_durum_n = BITTI;
               w_zaman_n = 1'b1;
               w_obek_n  = (r_sahip == GETIR) ? NOP_OBEK : '0;
            end else if (anabellek_musait_i) begin
               w_durum_n = YANIT;
            end
         end
         YANIT: begin
            w_sayac_n = r_sayac + SAYAC_BIT'(1);
            if (anabellek_veri_hazir_i) begin
               w_durum_n = BITTI;
               w_obek_n  = r_yaz ? '0 : anabellek_obek_i;
            end else if (w_son) begin
               w_durum_n = BITTI;
               w_zaman_n = 1'b1;
               w_obek_n  = (r_sahip == GETIR) ? NOP_OBEK : '0;
            end
         end
         BITTI: begin
            w_durum_n = BOSTA;
         end
         default: begin
            w_durum_n = BOSTA;
         end
      endcase
   end

   // State, context and registered outputs derived from the next state
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_durum        <= BOSTA;
         r_sahip        <= GETIR;
         r_adres        <= '0;
         r_yaz          <= 1'b0;
         r_yobek        <= '0;
         r_sayac        <= '0;
         r_mem_istek    <= 1'b0;
         r_mem_oku      <= 1'b0;
         r_mem_yaz      <= 1'b0;
         r_musait       <= 1'b0;
         r_getir_hazir  <= 1'b0;
         r_bellek_hazir <= 1'b0;
         r_getir_obek   <= '0;
         r_bellek_obek  <= '0;
         r_zaman        <= 1'b0;
      end else begin
         r_durum        <= w_durum_n;
         r_sahip        <= w_sahip_n;
         r_adres        <= w_adres_n;
         r_yaz          <= w_yaz_n;
         r_yobek        <= w_yobek_n;
         r_sayac        <= w_sayac_n;
         r_mem_istek    <= (w_durum_n == ISTEK);
         r_mem_oku      <= (w_durum_n == ISTEK) & ~w_yaz_n;
         r_mem_yaz      <= (w_durum_n == ISTEK) & w_yaz_n;
         r_musait       <= (w_durum_n == BOSTA);
         r_getir_hazir  <= (w_durum_n == BITTI) & (w_sahip_n == GETIR);
         r_bellek_hazir <= (w_durum_n == BITTI) & (w_sahip_n == BELLEK);
         r_getir_obek   <= (w_sahip_n == GETIR)  ? w_obek_n : '0;
         r_bellek_obek  <= (w_sahip_n == BELLEK) ? w_obek_n : '0;
         r_zaman        <= w_zaman_n;
      end
   end

   assign getir_musait_o       = r_musait;
   assign bellek_musait_o      = r_musait;
   assign getir_veri_hazir_o   = r_getir_hazir;
   assign bellek_veri_hazir_o  = r_bellek_hazir;
   assign getir_obek_o         = r_getir_obek;
   assign bellek_obek_o        = r_bellek_obek;
   assign anabellek_istek_o    = r_mem_istek;
   assign anabellek_adres_o    = r_adres;
   assign anabellek_oku_o      = r_mem_oku;
   assign anabellek_yaz_o      = r_mem_yaz;
   assign anabellek_yaz_obek_o = r_yobek;
   assign zaman_asimi_o        = r_zaman;

endmodule

// File: tb/tb_anabellek_hakem.sv
// Self-checking bench for anabellek_hakem: vector table with a scoreboard queue, plus reset and stray-response sequences.
module tb_anabellek_hakem;

   localparam int unsigned AB = 32;
   localparam int unsigned OB = 128;
   localparam int unsigned ZA = 8;
   localparam int NV = 9;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          getir_istek_i;
   logic [AB-1:0] getir_adres_i;
   logic          getir_musait_o;
   logic          getir_veri_hazir_o;
   logic [OB-1:0] getir_obek_o;
   logic          bellek_istek_i;
   logic [AB-1:0] bellek_adres_i;
   logic          bellek_yaz_i;
   logic [OB-1:0] bellek_yaz_obek_i;
   logic          bellek_musait_o;
   logic          bellek_veri_hazir_o;
   logic [OB-1:0] bellek_obek_o;
   logic          anabellek_istek_o;
   logic [AB-1:0] anabellek_adres_o;
   logic          anabellek_oku_o;
   logic          anabellek_yaz_o;
   logic [OB-1:0] anabellek_yaz_obek_o;
   logic          anabellek_musait_i;
   logic          anabellek_veri_hazir_i;
   logic [OB-1:0] anabellek_obek_i;
   logic          zaman_asimi_o;

   anabellek_hakem #(.ADRES_BIT(AB), .OBEK_BIT(OB), .ZAMAN_ASIMI(ZA)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .getir_istek_i(getir_istek_i), .getir_adres_i(getir_adres_i),
      .getir_musait_o(getir_musait_o), .getir_veri_hazir_o(getir_veri_hazir_o),
      .getir_obek_o(getir_obek_o),
      .bellek_istek_i(bellek_istek_i), .bellek_adres_i(bellek_adres_i),
      .bellek_yaz_i(bellek_yaz_i), .bellek_yaz_obek_i(bellek_yaz_obek_i),
      .bellek_musait_o(bellek_musait_o), .bellek_veri_hazir_o(bellek_veri_hazir_o),
      .bellek_obek_o(bellek_obek_o),
      .anabellek_istek_o(anabellek_istek_o), .anabellek_adres_o(anabellek_adres_o),
      .anabellek_oku_o(anabellek_oku_o), .anabellek_yaz_o(anabellek_yaz_o),
      .anabellek_yaz_obek_o(anabellek_yaz_obek_o),
      .anabellek_musait_i(anabellek_musait_i), .anabellek_veri_hazir_i(anabellek_veri_hazir_i),
      .anabellek_obek_i(anabellek_obek_i), .zaman_asimi_o(zaman_asimi_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          g_req;
      logic [AB-1:0] g_adr;
      logic          b_req;
      logic [AB-1:0] b_adr;
      logic          yaz;
      logic [OB-1:0] yobek;
      int            musait_gec;  // cycles memory holds musait_i low
      int            yanit_gec;   // YANIT cycle carrying the response, -1 = never
      logic [OB-1:0] mem_obek;
      logic          exp_bellek;
      logic [OB-1:0] exp_obek;
      logic          exp_zaman;
   } vec_t;

   typedef struct {
      logic          bellek;
      logic [OB-1:0] obek;
      logic          zaman;
   } bek_t;

   vec_t vecs [NV];
   bek_t sb [$];
   int   n_chk = 0;
   int   n_pass = 0;

   task automatic chk(input string ad, input logic [OB-1:0] gercek, input logic [OB-1:0] beklenen);
      n_chk++;
      if (gercek === beklenen) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", ad, gercek, beklenen);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      bek_t b;
      int   held, phase, yan, rsp_cyc;
      logic bitti;
      v = vecs[i];
      for (int k = 0; k < 10 && !getir_musait_o; k++) @(negedge clk_i);
      chk($sformatf("v%0d_musait_on", i), 128'(getir_musait_o & bellek_musait_o), 128'(1));
      getir_istek_i     = v.g_req;
      getir_adres_i     = v.g_adr;
      bellek_istek_i    = v.b_req;
      bellek_adres_i    = v.b_adr;
      bellek_yaz_i      = v.yaz;
      bellek_yaz_obek_i = v.yobek;
      b.bellek = v.exp_bellek;
      b.obek   = v.exp_obek;
      b.zaman  = v.exp_zaman;
      sb.push_back(b);
      held = 0; phase = 0; yan = 0; rsp_cyc = -100; bitti = 1'b0;
      for (int cyc = 1; cyc <= 60 && !bitti; cyc++) begin
         @(negedge clk_i);
         anabellek_musait_i     = 1'b0;
         anabellek_veri_hazir_i = 1'b0;
         if (getir_veri_hazir_o || bellek_veri_hazir_o) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d_beklenmeyen_yanit", i), 128'(1), 128'(0));
            end else begin
               b = sb.pop_front();
               chk($sformatf("v%0d_kazanan", i), 128'({getir_veri_hazir_o, bellek_veri_hazir_o}),
                   128'({~b.bellek, b.bellek}));
               chk($sformatf("v%0d_obek", i), b.bellek ? bellek_obek_o : getir_obek_o, b.obek);
               chk($sformatf("v%0d_zaman_asimi", i), 128'(zaman_asimi_o), 128'(b.zaman));
               if (!b.zaman) begin
                  chk($sformatf("v%0d_yanit_gecikme", i), 128'(cyc - rsp_cyc), 128'(1));
                  chk($sformatf("v%0d_istek_suresi", i), 128'(held), 128'(v.musait_gec + 1));
               end
            end
            getir_istek_i  = 1'b0;
            bellek_istek_i = 1'b0;
            bitti = 1'b1;
         end else begin
            if (phase == 0 && anabellek_istek_o) begin
               held++;
               if (held == 1) chk($sformatf("v%0d_istek_gecikme", i), 128'(cyc), 128'(1));
               if (held == v.musait_gec + 1) begin
                  chk($sformatf("v%0d_adres", i), 128'(anabellek_adres_o),
                      128'(v.exp_bellek ? v.b_adr : v.g_adr));
                  chk($sformatf("v%0d_oku_yaz", i), 128'({anabellek_oku_o, anabellek_yaz_o}),
                      128'({~(v.exp_bellek & v.yaz), v.exp_bellek & v.yaz}));
                  if (v.exp_bellek && v.yaz)
                     chk($sformatf("v%0d_yaz_obek", i), anabellek_yaz_obek_o, v.yobek);
                  anabellek_musait_i = 1'b1;
                  phase = 1;
               end
            end else if (phase == 1) begin
               yan++;
               if (yan == v.yanit_gec) begin
                  anabellek_veri_hazir_i = 1'b1;
                  anabellek_obek_i       = v.mem_obek;
                  rsp_cyc = cyc;
                  phase = 2;
               end
            end
            if (cyc == 1) begin
               // Inputs move after sampling; the registered copy must be used
               getir_adres_i     = ~v.g_adr;
               bellek_adres_i    = ~v.b_adr;
               bellek_yaz_obek_i = ~v.yobek;
               bellek_yaz_i      = ~v.yaz;
            end
         end
      end
      if (!bitti) begin
         chk($sformatf("v%0d_tamamlanma", i), 128'(0), 128'(1));
         getir_istek_i  = 1'b0;
         bellek_istek_i = 1'b0;
         sb.delete();
      end
      @(negedge clk_i);
      chk($sformatf("v%0d_darbe_tek", i), 128'({getir_veri_hazir_o, bellek_veri_hazir_o, zaman_asimi_o}), 128'(0));
      chk($sformatf("v%0d_musait_geri", i), 128'(getir_musait_o & bellek_musait_o), 128'(1));
   endtask

   initial begin
      logic [OB-1:0] nop;
      nop = {4{32'h0000_0013}};
      //          g_req  g_adr         b_req  b_adr         yaz   yobek                                    m    d   mem_obek                                 exp_b exp_obek                                 zaman
      vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0,        1'b0, 128'h0,                                   0,   3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5, 1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5, 1'b0};
      vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_2000, 1'b1, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 4,   2, {4{32'hFFFF_FFFF}},                       1'b1, 128'h0,                                   1'b0};
      vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 128'h0,                                   1,   1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_3800, 1'b0, 32'h0,        1'b0, 128'h0,                                   0,  -1, 128'h0,                                   1'b0, nop,                                      1'b1};
`ifdef HAKEM_DONUSUMLU_EN
      vecs[4] = '{1'b1, 32'h0000_4000, 1'b1, 32'h0000_4400, 1'b0, 128'h0, 0, 2, 128'hA1, 1'b1, 128'hA1, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_5000, 1'b1, 32'h0000_5400, 1'b0, 128'h0, 0, 2, 128'hB2, 1'b0, 128'hB2, 1'b0};
      vecs[6] = '{1'b1, 32'h0000_6000, 1'b1, 32'h0000_6400, 1'b0, 128'h0, 0, 2, 128'hC3, 1'b1, 128'hC3, 1'b0};
`else
      vecs[4] = '{1'b1, 32'h0000_4000, 1'b1, 32'h0000_4400, 1'b0, 128'h0, 0, 2, 128'hA1, 1'b1, 128'hA1, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_5000, 1'b1, 32'h0000_5400, 1'b0, 128'h0, 0, 2, 128'hB2, 1'b1, 128'hB2, 1'b0};
      vecs[6] = '{1'b1, 32'h0000_6000, 1'b1, 32'h0000_6400, 1'b0, 128'h0, 0, 2, 128'hC3, 1'b1, 128'hC3, 1'b0};
`endif
      vecs[7] = '{1'b0, 32'h0,         1'b1, 32'h0000_7000, 1'b0, 128'h0,                                 100,  -1, 128'h0,                                   1'b1, 128'h0,                                   1'b1};
      vecs[8] = '{1'b1, 32'h0000_8000, 1'b0, 32'h0,        1'b0, 128'h0,                                   0,   7, 128'h5A5A_0000_0000_0000_0000_0000_0000_5A5A, 1'b0, 128'h5A5A_0000_0000_0000_0000_0000_0000_5A5A, 1'b0};

      rst_i = 1'b0;
      getir_istek_i = 1'b0; getir_adres_i = '0;
      bellek_istek_i = 1'b0; bellek_adres_i = '0; bellek_yaz_i = 1'b0; bellek_yaz_obek_i = '0;
      anabellek_musait_i = 1'b0; anabellek_veri_hazir_i = 1'b0; anabellek_obek_i = '0;
      repeat (2) @(negedge clk_i);
      chk("reset_cikislar", 128'({getir_musait_o, bellek_musait_o, getir_veri_hazir_o, bellek_veri_hazir_o,
                                 anabellek_istek_o, anabellek_oku_o, anabellek_yaz_o, zaman_asimi_o}), 128'(0));
      chk("reset_adres", 128'(anabellek_adres_o), 128'(0));
      chk("reset_obek", getir_obek_o | bellek_obek_o, 128'(0));
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("reset_sonrasi_musait", 128'(getir_musait_o & bellek_musait_o), 128'(1));

      // Stray memory response while idle
      anabellek_veri_hazir_i = 1'b1;
      anabellek_obek_i = {4{32'h1234_5678}};
      @(negedge clk_i);
      anabellek_veri_hazir_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bosta_basibos_%0d", k), 128'({getir_veri_hazir_o, bellek_veri_hazir_o, anabellek_istek_o,
                                                     getir_musait_o}), 128'(1));
         @(negedge clk_i);
      end

      for (int i = 0; i < NV; i++) run_vec(i);

      // Reset while waiting for the memory response
      getir_istek_i = 1'b1;
      getir_adres_i = 32'h0000_9000;
      for (int k = 0; k < 5 && !anabellek_istek_o; k++) @(negedge clk_i);
      chk("rst_yanit_istek", 128'(anabellek_istek_o), 128'(1));
      anabellek_musait_i = 1'b1;
      @(negedge clk_i);
      anabellek_musait_i = 1'b0;
      chk("rst_yanit_strobe_dusuk", 128'({anabellek_istek_o, anabellek_oku_o}), 128'(0));
      #2 rst_i = 1'b0;
      #1;
      chk("rst_aninda_sifir", 128'({getir_musait_o, getir_veri_hazir_o, bellek_veri_hazir_o,
                                   anabellek_istek_o, zaman_asimi_o}), 128'(0));
      chk("rst_aninda_adres", 128'(anabellek_adres_o), 128'(0));
      anabellek_veri_hazir_i = 1'b1;
      @(negedge clk_i);
      anabellek_veri_hazir_i = 1'b0;
      rst_i = 1'b1;
      getir_istek_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk($sformatf("rst_sonrasi_yanit_yok_%0d", k), 128'({getir_veri_hazir_o, bellek_veri_hazir_o}), 128'(0));
      end
      chk("rst_sonrasi_musait", 128'(getir_musait_o), 128'(1));
      run_vec(0);
      run_vec(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
